// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator: decodes the M-stage op, drives data_memory for MEM_LATENCY cycles, returns m_valM/m_stat.
// Define MEM_ACCESS_STATS_EN to build the cnt_rd/cnt_wr/cnt_err access counters; otherwise they read as 0.
module mem_access_ctrl #(
  parameter int unsigned MEM_WORDS   = 8192,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_valid,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [2:0]  M_stat,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_data,
  input  logic        dmem_error,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic        m_done,
  output logic        m_busy,
  output logic [31:0] cnt_rd,
  output logic [31:0] cnt_wr,
  output logic [31:0] cnt_err
);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [2:0] S_AOK    = 3'd1;
  localparam logic [2:0] S_ADR    = 3'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic        err_q, err_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [63:0] valm_q, valm_d;
  logic [2:0]  stat_q, stat_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        is_rd, is_wr, addr_ok;
  logic [63:0] addr_sel;

  assign is_rd    = (M_icode == I_MRMOVQ) || (M_icode == I_POPQ) || (M_icode == I_RET);
  assign is_wr    = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) || (M_icode == I_CALL);
  // Only mrmovq and the writes address through valE; popq/ret use the stack pointer in valA.
  assign addr_sel = ((M_icode == I_MRMOVQ) || is_wr) ? M_valE : M_valA;
  assign addr_ok  = addr_sel < 64'(MEM_WORDS);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    valm_d  = valm_q;
    stat_d  = stat_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (M_valid) begin
          busy_d = 1'b1;
          if ((M_stat != S_AOK) || !(is_rd || is_wr)) begin
            state_d = DONE;
            done_d  = 1'b1;
            valm_d  = '0;
            stat_d  = M_stat;
          end else if (!addr_ok) begin
            state_d = DONE;
            done_d  = 1'b1;
            valm_d  = '0;
            stat_d  = S_ADR;
          end else begin
            state_d = ACCESS;
            addr_d  = addr_sel;
            wdata_d = is_wr ? M_valA : '0;
            rd_d    = is_rd;
            wr_d    = is_wr;
            lat_d   = 4'(MEM_LATENCY - 1);
            err_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        err_d = err_q | dmem_error;
        if (lat_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          valm_d  = rd_q ? mem_data : '0;
          stat_d  = (err_q || dmem_error) ? S_ADR : S_AOK;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      valm_q  <= '0;
      stat_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign m_valM    = valm_q;
  assign m_stat    = stat_q;
  assign m_done    = done_q;
  assign m_busy    = busy_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] cnt_rd_q, cnt_rd_d;
  logic [31:0] cnt_wr_q, cnt_wr_d;
  logic [31:0] cnt_err_q, cnt_err_d;
  logic        op_rd_q, op_rd_d;
  logic        op_wr_q, op_wr_d;
  logic        gen_err_q, gen_err_d;

  // Op kind and locally raised ADR are tracked alongside the FSM so the DONE cycle knows what to count.
  always_comb begin
    cnt_rd_d  = cnt_rd_q;
    cnt_wr_d  = cnt_wr_q;
    cnt_err_d = cnt_err_q;
    op_rd_d   = op_rd_q;
    op_wr_d   = op_wr_q;
    gen_err_d = gen_err_q;
    if ((state_q == IDLE) && M_valid) begin
      op_rd_d   = 1'b0;
      op_wr_d   = 1'b0;
      gen_err_d = 1'b0;
      if ((M_stat == S_AOK) && (is_rd || is_wr)) begin
        if (!addr_ok) begin
          gen_err_d = 1'b1;
        end else begin
          op_rd_d = is_rd;
          op_wr_d = is_wr;
        end
      end
    end
    if ((state_q == ACCESS) && (lat_q == '0) && (err_q || dmem_error)) begin
      gen_err_d = 1'b1;
    end
    if (state_q == DONE) begin
      if (gen_err_q) begin
        cnt_err_d = cnt_err_q + 32'd1;
      end else if (op_rd_q) begin
        cnt_rd_d = cnt_rd_q + 32'd1;
      end else if (op_wr_q) begin
        cnt_wr_d = cnt_wr_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_rd_q  <= '0;
      cnt_wr_q  <= '0;
      cnt_err_q <= '0;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      gen_err_q <= 1'b0;
    end else begin
      cnt_rd_q  <= cnt_rd_d;
      cnt_wr_q  <= cnt_wr_d;
      cnt_err_q <= cnt_err_d;
      op_rd_q   <= op_rd_d;
      op_wr_q   <= op_wr_d;
      gen_err_q <= gen_err_d;
    end
  end

  assign cnt_rd  = cnt_rd_q;
  assign cnt_wr  = cnt_wr_q;
  assign cnt_err = cnt_err_q;
`else
  assign cnt_rd  = '0;
  assign cnt_wr  = '0;
  assign cnt_err = '0;
`endif

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface for the pipeline Memory stage.
- Accepts one M-stage instruction (icode, valE, valA, stat) and decodes whether it reads, writes or skips memory.
- Drives mem_addr / write data / mem_read / mem_write to data_memory, holds them for a programmable access latency, and returns m_valM and m_stat with a done pulse and a busy/stall signal toward pipeline control.

Parameters:
- MEM_WORDS, 8192, number of addressable entries in data_memory; a valid address is < MEM_WORDS.
- MEM_LATENCY, 1, cycles mem_read/mem_write are held before mem_data is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- M_valid  input  1  M-stage instruction present; sampled only in IDLE.
- M_icode  input  4  Y86 icode.
- M_valE  input  64  ALU result / computed address.
- M_valA  input  64  register operand / valP / stack pointer.
- M_stat  input  3  incoming status (1 AOK, 2 HLT, 3 ADR, 4 INS).
- mem_addr  output  64  address to data_memory.
- mem_wdata  output  64  write data to data_memory.
- mem_read  output  1  read strobe.
- mem_write  output  1  write strobe.
- mem_data  input  64  read data from data_memory.
- dmem_error  input  1  error from data_memory.
- m_valM  output  64  read result; 0 for non-read ops.
- m_stat  output  3  outgoing status.
- m_done  output  1  one-cycle pulse: m_valM/m_stat valid.
- m_busy  output  1  high whenever state != IDLE; the pipeline stalls M.
- cnt_rd  output  32  completed reads (optional feature).
- cnt_wr  output  32  completed writes (optional feature).
- cnt_err  output  32  ADR results raised here (optional feature).

Behaviour:
- Reset: all outputs 0, state IDLE, latency counter 0; applies immediately, including mid-access, and aborts any in-flight access.
- All outputs are registered.
- Decode:
  - Reads (address source): mrmovq 5 (valE), popq B (valA), ret 9 (valA).
  - Writes (address, data): rmmovq 4 (valE, valA), pushq A (valE, valA), call 8 (valE, valA).
  - Any other icode: no access.
- State machine: IDLE, ACCESS, DONE.
- IDLE, M_valid=1 (accept edge):
  - M_stat != AOK, or non-memory icode: go to DONE; m_valM=0, m_stat=M_stat.
  - Memory op with address >= MEM_WORDS: go to DONE with no strobe; m_stat=3.
  - Otherwise: go to ACCESS; latch mem_addr and mem_wdata; assert exactly one of mem_read/mem_write; load counter = MEM_LATENCY-1.
- IDLE, M_valid=0: stay.
- ACCESS:
  - Strobe, address and data held stable each cycle; counter decrements.
  - dmem_error seen in any ACCESS cycle sets a sticky error flag.
  - On the cycle the counter is 0: capture mem_data (reads only), deassert strobes, go to DONE.
  - m_stat = 3 if the error flag is set, else 1.
- DONE: m_done=1 for exactly one cycle, then IDLE. m_valM/m_stat hold until the next DONE.
- Latency from the accept edge:
  - Non-memory or bad-address op: m_done high after 1 edge.
  - Memory op: strobe high for MEM_LATENCY cycles; m_done high after MEM_LATENCY+1 edges.
- M_valid while m_busy=1 is ignored; the upstream stage holds its inputs.
- mem_read and mem_write are never both 1.
- A write that reports dmem_error still completes, returning ADR status and m_valM=0.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- Defined:
  - cnt_rd, cnt_wr, cnt_err are 32-bit counters, reset to 0.
  - cnt_rd / cnt_wr increment on the DONE cycle of an error-free read / write.
  - cnt_err increments on any DONE with m_stat=3 generated here (out-of-range address or dmem_error).
  - Counters wrap 0xFFFFFFFF -> 0.
- Not defined: the three ports are tied to 0 and no counter logic is built.

Test Plan:
- MEM_LATENCY=1; rmmovq (icode 4, valE=0x10, valA=0xDEAD) -> mem_write=1 for 1 cycle, addr 0x10, wdata 0xDEAD; m_done after 2 edges, m_stat=1.
- Then mrmovq (icode 5, valE=0x10) -> mem_read 1 cycle; m_valM=0xDEAD, m_stat=1, m_busy high for 2 cycles.
- MEM_LATENCY=3; popq (icode B, valA=0x20, mem holds 0x55) -> strobe 3 cycles, addr 0x20; m_done after 4 edges, m_valM=0x55.
- pushq with valE=8192 -> no strobe, m_done after 1 edge, m_stat=3; cnt_err=1 with MEM_ACCESS_STATS_EN.
- OPq (icode 6) with M_stat=2 -> no strobe, m_done after 1 edge, m_stat=2, m_valM=0; M_valid pulsed while busy -> ignored.
- rst asserted during the 2nd ACCESS cycle (MEM_LATENCY=3) -> mem_read, m_busy, m_done drop to 0 immediately; next op completes normally.
